mlsd_err_checker: RTL
=====================

Name: mlsd_err_checker

Overview:
- Downstream checker for flat_mlsd.
- Consumes the per-lane predict_bits and compares them against a reference bit vector, such as the slicer estimate_bits or the PRBS/bench bits.
- Searches for the pipeline delay between the two streams, locks to it, then accumulates saturating error and bit counters for BER measurement in silicon and in simulation.

Parameters:
- numChannels, 32, lanes per cycle; width of the bit vectors.
- maxDelay, 7, largest reference delay searched, in clock cycles.
- alignWindow, 16, error-free cycles required to accept a candidate delay.
- errBitwidth, 32, width of err_count and bit_count.

Ports:
- clk  input  1  system clock.
- rstb  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins delay search from IDLE.
- clear  input  1  synchronous; returns to IDLE and zeroes counters.
- predict_bits  input  [numChannels]  flat_mlsd predict_bits, one bit per lane.
- ref_bits  input  [numChannels]  reference bits, same lane order.
- locked  output  1  high while in CHECK.
- align_fail  output  1  sticky; no delay passed the search.
- delay  output  $clog2(maxDelay+1)  locked delay value.
- err_count  output  errBitwidth  accumulated mismatched bits.
- bit_count  output  errBitwidth  accumulated compared bits.
- err_sat  output  1  sticky; a counter has saturated.

Behaviour:
- Reset: already decided. One clock, clk. Reset rstb is asynchronous, active-low. While rstb=0:
  - state=IDLE;
  - all outputs 0;
  - reference history zeroed;
  - all internal counters zeroed.
- Reference history: ref_hist[0] = ref_bits (current cycle). ref_hist[k] = ref_bits from k cycles earlier, k=1..maxDelay. The history shifts every cycle in every state.
- Mismatch vector: mm(d) = predict_bits XOR ref_hist[d]. nerr(d) = popcount(mm(d)), width $clog2(numChannels+1).
- FSM states: IDLE, FILL, ALIGN, CHECK.
- IDLE:
  - Waits for start. On start=1 (and clear=0): go to FILL, clear align_fail, zero err_count/bit_count/err_sat, set cand=0.
- FILL:
  - Runs exactly maxDelay cycles so the history is valid, then goes to ALIGN.
- ALIGN:
  - Window counter runs 0..alignWindow-1. Each cycle, flag window_bad if nerr(cand)!=0.
  - At the last window cycle, evaluate. Include that cycle's own nerr in the evaluation.
  - If the window is clean: delay<=cand, go to CHECK. locked=1 on the following cycle.
  - Else, if cand<maxDelay: cand++, reset window counter and window_bad.
  - Else (cand=maxDelay failed): align_fail<=1, go to IDLE.
  - The smallest passing delay wins.
- CHECK:
  - Every cycle: err_count += nerr(delay); bit_count += numChannels. Both update at the next edge (1-cycle latency).
  - Arithmetic is unsigned, sized errBitwidth+1 internally.
  - If either sum exceeds 2^errBitwidth-1: that counter clamps to all-ones, err_sat<=1, and both counters freeze.
  - Stays in CHECK until clear or reset.
- clear=1 in any state: next cycle state=IDLE, locked=0, err_count=0, bit_count=0, err_sat=0, align_fail=0, delay=0.
  - clear has priority over start and over any FSM transition on the same cycle.
- start while not in IDLE: ignored.
- Reset asserted mid-ALIGN or mid-CHECK: immediate return to reset values. No partial result is retained.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset: hold rstb=0 with random inputs toggling -> all outputs 0. After release with no start, state remains IDLE and outputs remain 0.
- Lock at delay 3: predict_bits = random stream; ref_bits = same stream advanced 3 cycles (ref leads predict by 3). Pulse start -> locked=1 and delay=3 exactly 71 cycles after the start edge (7 FILL + 4×16 ALIGN). align_fail=0.
- Error injection: locked at delay 3, then flip 5 bits of predict_bits in one cycle.
  - err_count increases by exactly 5 one cycle later.
  - bit_count increases by 32 every cycle.
  - After 10 clean cycles, err_count stays 5.
- Align failure: predict_bits and ref_bits independent random. Pulse start -> align_fail=1 and state IDLE after 135 cycles (7 + 8×16). locked=0, counters 0.
- Saturation: errBitwidth=8, locked at delay 0 -> bit_count sequence 0,32,…,224 then 255; err_sat=1; err_count and bit_count frozen afterwards.
- Clear and reset mid-operation:
  - clear asserted in CHECK together with start -> IDLE, all counters 0, start ignored.
  - rstb pulsed low mid-ALIGN -> outputs 0 immediately.
  - A new start then relocks at the same delay after 71 cycles.

Source files
------------

// File: rtl/mlsd_err_checker_if.sv
// Bus bundle for mlsd_err_checker.
//   master : drives start/clear/predict_bits/ref_bits, observes status/counters
//   slave  : the checker itself
interface mlsd_err_checker_if #(
  parameter int unsigned numChannels = 32,
  parameter int unsigned maxDelay    = 7,
  parameter int unsigned errBitwidth = 32
);
  localparam int unsigned DelayW = (maxDelay > 0) ? $clog2(maxDelay + 1) : 1;

  logic                   start;
  logic                   clear;
  logic [numChannels-1:0] predict_bits;
  logic [numChannels-1:0] ref_bits;
  logic                   locked;
  logic                   align_fail;
  logic [DelayW-1:0]      delay;
  logic [errBitwidth-1:0] err_count;
  logic [errBitwidth-1:0] bit_count;
  logic                   err_sat;

  modport master (
    output start, clear, predict_bits, ref_bits,
    input  locked, align_fail, delay, err_count, bit_count, err_sat
  );

  modport slave (
    input  start, clear, predict_bits, ref_bits,
    output locked, align_fail, delay, err_count, bit_count, err_sat
  );
endinterface

// File: rtl/mlsd_err_checker.sv
// BER checker downstream of flat_mlsd: finds the delay between predict_bits
// and a reference stream, locks to it and accumulates saturating error/bit
// counters.
//   clk, rstb : clock, asynchronous active-low reset
//   bus       : start/clear pulses, predict/ref vectors in; locked,
//               align_fail, delay, err_count, bit_count, err_sat out
//               (all outputs registered)
module mlsd_err_checker #(
  parameter int unsigned numChannels = 32,
  parameter int unsigned maxDelay    = 7,
  parameter int unsigned alignWindow = 16,
  parameter int unsigned errBitwidth = 32
) (
  input  logic               clk,
  input  logic               rstb,
  mlsd_err_checker_if.slave  bus
);

  localparam int unsigned DelayW = (maxDelay > 0) ? $clog2(maxDelay + 1) : 1;
  localparam int unsigned NerrW  = $clog2(numChannels + 1);
  localparam int unsigned WinW   = (alignWindow > 1) ? $clog2(alignWindow) : 1;
  localparam int unsigned HistD  = (maxDelay > 0) ? maxDelay : 1;
  localparam int unsigned SumW   = errBitwidth + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] ALIGN = 2'd2;
  localparam logic [1:0] CHECK = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [numChannels-1:0] hist_q [1:HistD];
  logic [numChannels-1:0] hist_d [1:HistD];
  logic [DelayW-1:0]      fill_cnt_q, fill_cnt_d;
  logic [WinW-1:0]        win_cnt_q, win_cnt_d;
  logic                   window_bad_q, window_bad_d;
  logic [DelayW-1:0]      cand_q, cand_d;
  logic [DelayW-1:0]      delay_q, delay_d;
  logic                   locked_q, locked_d;
  logic                   align_fail_q, align_fail_d;
  logic [errBitwidth-1:0] err_count_q, err_count_d;
  logic [errBitwidth-1:0] bit_count_q, bit_count_d;
  logic                   err_sat_q, err_sat_d;

  logic [numChannels-1:0] ref_cand, ref_lock;
  logic [NerrW-1:0]       nerr_cand, nerr_lock;
  logic                   bad_now;
  logic [SumW-1:0]        err_sum, bit_sum;

  function automatic logic [NerrW-1:0] popcnt(input logic [numChannels-1:0] v);
    logic [NerrW-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < numChannels; i++) begin
      cnt = cnt + NerrW'(v[i]);
    end
    return cnt;
  endfunction

  // Reference history: entry k holds ref_bits from k cycles ago.
  always_comb begin
    hist_d[1] = bus.ref_bits;
    for (int unsigned k = 2; k <= HistD; k++) begin
      hist_d[k] = hist_q[k-1];
    end
  end

  // Select the reference taps for the candidate and the locked delay.
  always_comb begin
    ref_cand = bus.ref_bits;
    ref_lock = bus.ref_bits;
    for (int unsigned k = 1; k <= HistD; k++) begin
      if (DelayW'(k) == cand_q)  ref_cand = hist_q[k];
      if (DelayW'(k) == delay_q) ref_lock = hist_q[k];
    end
  end

  assign nerr_cand = popcnt(bus.predict_bits ^ ref_cand);
  assign nerr_lock = popcnt(bus.predict_bits ^ ref_lock);
  assign bad_now   = window_bad_q | (nerr_cand != '0);
  assign err_sum   = {1'b0, err_count_q} + SumW'(nerr_lock);
  assign bit_sum   = {1'b0, bit_count_q} + SumW'(numChannels);

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    win_cnt_d    = win_cnt_q;
    window_bad_d = window_bad_q;
    cand_d       = cand_q;
    delay_d      = delay_q;
    align_fail_d = align_fail_q;
    err_count_d  = err_count_q;
    bit_count_d  = bit_count_q;
    err_sat_d    = err_sat_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d      = FILL;
          fill_cnt_d   = '0;
          cand_d       = '0;
          align_fail_d = 1'b0;
          err_count_d  = '0;
          bit_count_d  = '0;
          err_sat_d    = 1'b0;
        end
      end

      FILL: begin
        fill_cnt_d = fill_cnt_q + DelayW'(1);
        if (fill_cnt_q == DelayW'(maxDelay - 1)) begin
          state_d      = ALIGN;
          win_cnt_d    = '0;
          window_bad_d = 1'b0;
        end
      end

      ALIGN: begin
        window_bad_d = bad_now;
        win_cnt_d    = win_cnt_q + WinW'(1);
        // Evaluate on the last window cycle, including its own mismatches.
        if (win_cnt_q == WinW'(alignWindow - 1)) begin
          if (!bad_now) begin
            delay_d = cand_q;
            state_d = CHECK;
          end else if (cand_q < DelayW'(maxDelay)) begin
            cand_d       = cand_q + DelayW'(1);
            win_cnt_d    = '0;
            window_bad_d = 1'b0;
          end else begin
            align_fail_d = 1'b1;
            state_d      = IDLE;
          end
        end
      end

      CHECK: begin
        // Once either counter saturates, both freeze.
        if (!err_sat_q) begin
          if (err_sum[errBitwidth] || bit_sum[errBitwidth]) begin
            err_count_d = err_sum[errBitwidth] ? '1 : err_sum[errBitwidth-1:0];
            bit_count_d = bit_sum[errBitwidth] ? '1 : bit_sum[errBitwidth-1:0];
            err_sat_d   = 1'b1;
          end else begin
            err_count_d = err_sum[errBitwidth-1:0];
            bit_count_d = bit_sum[errBitwidth-1:0];
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // clear overrides start and every FSM transition.
    if (bus.clear) begin
      state_d      = IDLE;
      fill_cnt_d   = '0;
      win_cnt_d    = '0;
      window_bad_d = 1'b0;
      cand_d       = '0;
      delay_d      = '0;
      align_fail_d = 1'b0;
      err_count_d  = '0;
      bit_count_d  = '0;
      err_sat_d    = 1'b0;
    end

    locked_d = (state_d == CHECK);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= IDLE;
      for (int unsigned k = 1; k <= HistD; k++) begin
        hist_q[k] <= '0;
      end
      fill_cnt_q   <= '0;
      win_cnt_q    <= '0;
      window_bad_q <= 1'b0;
      cand_q       <= '0;
      delay_q      <= '0;
      locked_q     <= 1'b0;
      align_fail_q <= 1'b0;
      err_count_q  <= '0;
      bit_count_q  <= '0;
      err_sat_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hist_q       <= hist_d;
      fill_cnt_q   <= fill_cnt_d;
      win_cnt_q    <= win_cnt_d;
      window_bad_q <= window_bad_d;
      cand_q       <= cand_d;
      delay_q      <= delay_d;
      locked_q     <= locked_d;
      align_fail_q <= align_fail_d;
      err_count_q  <= err_count_d;
      bit_count_q  <= bit_count_d;
      err_sat_q    <= err_sat_d;
    end
  end

  assign bus.locked     = locked_q;
  assign bus.align_fail = align_fail_q;
  assign bus.delay      = delay_q;
  assign bus.err_count  = err_count_q;
  assign bus.bit_count  = bit_count_q;
  assign bus.err_sat    = err_sat_q;

endmodule
